// File: rtl/drowsiness_feature_writer.sv
// drowsiness_feature_writer
//   Write side of the drowsiness feature store. A valid/ready byte stream
//   carrying one feature vector is written feature by feature into the flat
//   SAMPLE_COUNT*FEATURE_COUNT array, starting at slot start_index. The block
//   keeps one valid bit per slot so that readers only see complete samples.
//
// Configuration macro: CHECKSUM_EN
//   Defined   : after the last feature one extra byte is accepted and compared
//               with the XOR of the features. That byte is not written. A
//               mismatch sets chk_err and keeps the slot invalid.
//   Undefined : no checksum byte is taken and chk_err is tied to 0.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
//   in_ready depends only on the FSM state and never on in_valid.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            one-cycle pulse that begins a load; ignored while busy
//   start_index      target slot, sampled together with start
//   in_valid/in_data/in_ready   feature byte stream
//   mem_we/mem_addr/mem_wdata   registered array write port (1-cycle latency)
//   busy             load in progress (LOAD/CHECK/DONE)
//   done             one-cycle pulse at the end of a load
//   err              sticky: start_index was out of range
//   chk_err          sticky: checksum mismatch
//   sample_valid     bit i set = slot i holds a complete sample
module drowsiness_feature_writer #(
    parameter int FEATURE_WIDTH = 8,
    parameter int FEATURE_COUNT = 136,
    parameter int SAMPLE_COUNT  = 10,
    localparam int IDX_W  = $clog2(SAMPLE_COUNT),
    localparam int ADDR_W = $clog2(FEATURE_COUNT * SAMPLE_COUNT),
    localparam int CNT_W  = $clog2(FEATURE_COUNT + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [IDX_W-1:0]         start_index,
    input  logic                     in_valid,
    input  logic [FEATURE_WIDTH-1:0] in_data,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [FEATURE_WIDTH-1:0] mem_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     chk_err,
    output logic [SAMPLE_COUNT-1:0]  sample_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  feat_cnt;
    logic [IDX_W-1:0]  slot;

    logic handshake;
    logic start_ok;
    logic last_byte;

    assign handshake = in_valid && in_ready;
    assign start_ok  = start && (32'(start_index) < SAMPLE_COUNT);
    assign last_byte = (feat_cnt == CNT_W'(FEATURE_COUNT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_ok) state_next = LOAD;
            LOAD: begin
                if (handshake && last_byte) begin
`ifdef CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
`endif
                end
            end
            CHECK: if (handshake) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready = (state == LOAD) || (state == CHECK);
        busy     = (state != IDLE);
        done     = (state == DONE);
    end

`ifdef CHECKSUM_EN
    logic [FEATURE_WIDTH-1:0] xsum;
    logic                     chk_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xsum    <= '0;
            chk_reg <= 1'b0;
        end else if (state == IDLE && start_ok) begin
            xsum    <= '0;
            chk_reg <= 1'b0;
        end else if (state == LOAD && handshake) begin
            xsum <= xsum ^ in_data;
        end else if (state == CHECK && handshake && (in_data != xsum)) begin
            chk_reg <= 1'b1;
        end
    end

    assign chk_err = chk_reg;
`else
    assign chk_err = 1'b0;
`endif

    // Datapath: slot bookkeeping, registered write port, status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base         <= '0;
            feat_cnt     <= '0;
            slot         <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            err          <= 1'b0;
            sample_valid <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            base     <= ADDR_W'(32'(start_index) * FEATURE_COUNT);
                            feat_cnt <= '0;
                            slot     <= start_index;
                            err      <= 1'b0;
                            // Invalidate before the first word lands so readers
                            // never see a half-rewritten sample as valid.
                            sample_valid[start_index] <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= base + ADDR_W'(feat_cnt);
                        mem_wdata <= in_data;
                        feat_cnt  <= feat_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!chk_err) sample_valid[slot] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_drowsiness_feature_writer.sv
module tb_drowsiness_feature_writer;

    localparam int FW = 8;
    localparam int FC = 136;
    localparam int SC = 10;
    localparam int IW = 4;
    localparam int AW = 11;
`ifdef CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [IW-1:0] start_index;
    logic          in_valid;
    logic [FW-1:0] in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [FW-1:0] mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic          chk_err;
    logic [SC-1:0] sample_valid;

    drowsiness_feature_writer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_index(start_index),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .chk_err(chk_err),
        .sample_valid(sample_valid)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected writes {addr, data}
    logic [AW+FW-1:0] exp_q[$];
    logic [AW+FW-1:0] mon_e;
    logic [SC-1:0]    sv_model;
    logic [FW-1:0]    tb_xsum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=%0d required=none", mem_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== mon_e) begin
                    errors++;
                    $display("FAIL write actual=%0d/%0h required=%0d/%0h",
                             mem_addr, mem_wdata, mon_e[AW+FW-1:FW], mon_e[FW-1:0]);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     32'(busy), 0);
        check({tag, "_done"},     32'(done), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_mem_we"},   32'(mem_we), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_err"},      32'(err), 0);
        check({tag, "_chk_err"},  32'(chk_err), 0);
        check({tag, "_sv"},       32'(sample_valid), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0; start_index = '0; in_valid = 1'b0; in_data = '0;
        #1;
        check_all_zero("reset");
        exp_q.delete();
        sv_model = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Issue a start pulse; inputs change at posedge+1, outputs checked at negedge.
    task automatic start_cmd(input int idx, input bit exp_ok);
        start = 1'b1;
        start_index = IW'(idx);
        @(posedge clk);
        #1 start = 1'b0;
        if (exp_ok) sv_model[idx] = 1'b0;
        @(negedge clk);
        check("start_err",      32'(err), 32'(!exp_ok));
        check("start_busy",     32'(busy), 32'(exp_ok));
        check("start_in_ready", 32'(in_ready), 32'(exp_ok));
        check("start_mem_we",   32'(mem_we), 0);
        check("start_sv",       32'(sample_valid), 32'(sv_model));
        @(posedge clk);
        #1;
    endtask

    // Stream n bytes into slot idx. gap: 0 none, 1 one idle cycle between
    // bytes, 2 random. dmode: 0 index, 1 random, 2 constant 0x01.
    // A spurious start to slot 2 is presented together with byte inj.
    task automatic load_bytes(input int idx, input int n, input int gap,
                              input int dmode, input int inj);
        logic [FW-1:0] d;
        int ng;
        tb_xsum = '0;
        for (int k = 0; k < n; k++) begin
            ng = (gap == 1 && k > 0) ? 1 : (gap == 2) ? $urandom_range(0, 2) : 0;
            repeat (ng) begin
                @(posedge clk);
                #1;
            end
            d = (dmode == 0) ? FW'(k) : (dmode == 1) ? FW'($urandom_range(0, 255)) : 8'h01;
            if (k == inj) begin
                start = 1'b1;
                start_index = 4'd2;
            end
            in_valid = 1'b1;
            in_data = d;
            exp_q.push_back({AW'(idx * FC + k), d});
            tb_xsum = tb_xsum ^ d;
            @(negedge clk);
            check("in_ready_load", 32'(in_ready), 1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            start = 1'b0;
        end
    endtask

    // Complete a load after all features were sent; bad selects a wrong checksum.
    task automatic finish_load(input int idx, input bit bad);
`ifdef CHECKSUM_EN
        in_valid = 1'b1;
        in_data = tb_xsum ^ (bad ? 8'hFF : 8'h00);
        @(negedge clk);
        check("in_ready_chk", 32'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("done_pulse", 32'(done), 1);
        check("done_no_we", 32'(mem_we), 0);
        check("done_chk_err", 32'(chk_err), 32'(bad));
`else
        @(negedge clk);
        check("done_pulse", 32'(done), 1);
        check("done_last_we", 32'(mem_we), 1);
        check("done_last_addr", 32'(mem_addr), 32'(idx * FC + FC - 1));
        check("done_chk_err", 32'(chk_err), 0);
`endif
        if (!(bad && CHK)) sv_model[idx] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_done", 32'(done), 0);
        check("after_busy", 32'(busy), 0);
        check("after_sv", 32'(sample_valid), 32'(sv_model));
        check("queue_drained", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int idx;
        bit exp_err;
        int gap;
        int dmode;
        bit bad;
    } vec_t;

    vec_t vec[9];

    initial begin
        vec[0] = '{idx: 0,  exp_err: 0, gap: 0, dmode: 0, bad: 0};
        vec[1] = '{idx: 9,  exp_err: 0, gap: 1, dmode: 1, bad: 0};
        vec[2] = '{idx: 10, exp_err: 1, gap: 0, dmode: 0, bad: 0};
        vec[3] = '{idx: 15, exp_err: 1, gap: 0, dmode: 0, bad: 0};
        vec[4] = '{idx: 3,  exp_err: 0, gap: 2, dmode: 1, bad: 0};
        vec[5] = '{idx: 3,  exp_err: 0, gap: 0, dmode: 1, bad: 0};
        vec[6] = '{idx: 7,  exp_err: 0, gap: 2, dmode: 2, bad: 0};
        vec[7] = '{idx: 6,  exp_err: 0, gap: 0, dmode: 2, bad: 1};
        vec[8] = '{idx: 1,  exp_err: 0, gap: 2, dmode: 1, bad: 0};

        do_reset();
        @(posedge clk);
        #1;

        for (int v = 0; v < 9; v++) begin
            start_cmd(vec[v].idx, !vec[v].exp_err);
            if (!vec[v].exp_err) begin
                load_bytes(vec[v].idx, FC, vec[v].gap, vec[v].dmode, -1);
                finish_load(vec[v].idx, vec[v].bad);
            end else begin
                repeat (3) @(posedge clk);
                #1;
                @(negedge clk);
                check("err_sticky", 32'(err), 1);
                check("err_idle_busy", 32'(busy), 0);
                @(posedge clk);
                #1;
            end
        end

        // Start to slot 2 during a load of slot 5 is ignored; reset after 50 bytes.
        start_cmd(5, 1'b1);
        load_bytes(5, 50, 0, 1, 20);
        @(negedge clk);
        check("ignored_start_err", 32'(err), 0);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        check("midreset_queue", 32'(exp_q.size()), 0);
        exp_q.delete();
        sv_model = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_cmd(5, 1'b1);
        load_bytes(5, FC, 0, 0, -1);
        finish_load(5, 1'b0);

        // Randomized loads against the slot/address model
        for (int r = 0; r < 6; r++) begin
            int ridx;
            bit rbad;
            ridx = $urandom_range(0, 15);
            rbad = 1'($urandom_range(0, 1));
            start_cmd(ridx, ridx < SC);
            if (ridx < SC) begin
                load_bytes(ridx, FC, 2, 1, -1);
                finish_load(ridx, rbad);
            end
        end

        check("final_queue", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
